// File: rtl/uart_rx_if.sv
// Serial receive bus for uart_rx: the line and consumer controls in, the held byte and sticky flags out.
interface uart_rx_if;
  logic       rx;
  logic       rd_en;
  logic       clear_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  modport master (
    output rx, rd_en, clear_err,
    input  rx_data, rx_valid, overrun, frame_err, parity_err
  );

  modport slave (
    input  rx, rd_en, clear_err,
    output rx_data, rx_valid, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register and sticky error flags.
// Define UART_RX_PARITY_EN to expect one even-parity bit after bit 7.
module uart_rx #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int CPB = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CPB / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic          r_sync1, r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid, r_overrun, r_frame_err;

  logic          w_rx;
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_accept, w_frame_set, w_pop;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err;
  logic w_par_bad_nxt, w_par_set;
`endif

  assign w_rx  = r_sync2;
  assign w_pop = bus.rd_en & r_valid;

  // Idle-high synchronizer so a reset line never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_accept    = 1'b0;
    w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_set     = 1'b0;
    w_par_bad_nxt = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) w_state_nxt = S_START;
        else       w_state_nxt = S_IDLE;
      end
      // Mid-start-bit recheck rejects short glitches without flagging anything.
      S_START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt = '0;
          w_idx_nxt = 3'd0;
          if (!w_rx) w_state_nxt = S_DATA;
          else       w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt           = '0;
          w_shift_nxt[r_idx]  = w_rx;
          w_idx_nxt           = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt     = '0;
          w_state_nxt   = S_STOP;
          w_par_set     = (w_rx != even_parity(r_shift));
          w_par_bad_nxt = w_par_set;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
            w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
            w_accept    = ~r_par_bad;
`else
            w_accept    = 1'b1;
`endif
          end else begin
            w_state_nxt = S_BREAK;
            w_frame_set = 1'b1;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx) w_state_nxt = S_IDLE;
        else      w_state_nxt = S_BREAK;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register: a pop in the same cycle frees the slot for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_accept && !(r_valid && !w_pop)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      r_overrun   <= (w_accept & r_valid & ~w_pop) | (r_overrun & ~bus.clear_err);
      r_frame_err <= w_frame_set | (r_frame_err & ~bus.clear_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bad    <= w_par_bad_nxt;
      r_parity_err <= w_par_set | (r_parity_err & ~bus.clear_err);
    end
  end
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CPB=10: directed frame scenarios plus a randomized
// byte stream scoreboarded against a frame-level model.
module tb_uart_rx;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_rd, dir_rd, auto_pop, any_bad_stop;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];

  uart_rx_if bus ();

  assign bus.rd_en = mon_rd | dir_rd;

  uart_rx #(.SYS_CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},   bus.rx_data,    32'h00);
    check({tag, "_valid"},  bus.rx_valid,   32'h0);
    check({tag, "_ovr"},    bus.overrun,    32'h0);
    check({tag, "_ferr"},   bus.frame_err,  32'h0);
    check({tag, "_perr"},   bus.parity_err, 32'h0);
  endtask

  task automatic put_bit(input logic v);
    bus.rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Model: a frame yields a byte iff its stop bit is high (and, with parity, the parity is even).
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_bit);
    logic good;
    good = stop_ok;
`ifdef UART_RX_PARITY_EN
    good = good && (par_bit == ^b);
`endif
    if (auto_pop && good) exp_q.push_back(b);
    if (!stop_ok) any_bad_stop = 1'b1;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    put_bit(par_bit);
`endif
    put_bit(stop_ok);
  endtask

  task automatic pop_once();
    dir_rd = 1'b1;
    @(negedge clk);
    dir_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte in streaming mode.
  initial begin
    logic [7:0] e;
    mon_rd = 1'b0;
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (auto_pop && rst_n && bus.rx_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL mon_unexpected: got byte %02h, expected none", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rx_data !== e) begin
            n_err++;
            $display("FAIL mon_data: got %02h expected %02h", bus.rx_data, e);
          end
        end
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       st;
    rst_n = 1'b0;
    bus.rx = 1'b1;
    bus.clear_err = 1'b0;
    dir_rd = 1'b0;
    auto_pop = 1'b0;
    any_bad_stop = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    idle(5);
    check_reset_vals("post_rst");

    // Single good byte, then pop
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(2);
    check("a5_valid", bus.rx_valid, 32'h1);
    check("a5_data", bus.rx_data, 32'hA5);
    check("a5_flags", {bus.overrun, bus.frame_err, bus.parity_err}, 32'h0);
    pop_once();
    check("a5_popped", bus.rx_valid, 32'h0);
    check("a5_data_kept", bus.rx_data, 32'hA5);

    // Overrun: second byte dropped, first kept
    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    idle(2);
    check("ovr_data", bus.rx_data, 32'h3C);
    check("ovr_valid", bus.rx_valid, 32'h1);
    check("ovr_flag", bus.overrun, 32'h1);
    pulse_clear();
    check("ovr_cleared", bus.overrun, 32'h0);
    check("ovr_valid_after_clr", bus.rx_valid, 32'h1);
    pop_once();
    check("ovr_popped", bus.rx_valid, 32'h0);

    // Framing error followed by a held-low line
    send_frame(8'h55, 1'b0, ^8'h55);
    bus.rx = 1'b0;
    repeat (30) @(negedge clk);
    check("ferr_flag", bus.frame_err, 32'h1);
    check("ferr_valid", bus.rx_valid, 32'h0);
    repeat (30) @(negedge clk);
    check("brk_no_frame", bus.rx_valid, 32'h0);
    idle(10);
    pulse_clear();
    check("ferr_cleared", bus.frame_err, 32'h0);
    any_bad_stop = 1'b0;

    // Start-bit glitch rejection
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch_valid", bus.rx_valid, 32'h0);
    check("glitch_flags", {bus.overrun, bus.frame_err, bus.parity_err}, 32'h0);
    send_frame(8'h01, 1'b1, ^8'h01);
    idle(2);
    check("g01_valid", bus.rx_valid, 32'h1);
    check("g01_data", bus.rx_data, 32'h01);
    pop_once();

    // Reset mid-frame of 8'hFF
    put_bit(1'b0);
    repeat (4) put_bit(1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("rst_no_byte", bus.rx_valid, 32'h0);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(2);
    check("r12_valid", bus.rx_valid, 32'h1);
    check("r12_data", bus.rx_data, 32'h12);
    pop_once();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle(2);
    check("par_err", bus.parity_err, 32'h1);
    check("par_bad_valid", bus.rx_valid, 32'h0);
    pulse_clear();
    send_frame(8'h03, 1'b1, 1'b0);
    idle(2);
    check("par_ok_valid", bus.rx_valid, 32'h1);
    check("par_ok_data", bus.rx_data, 32'h03);
    check("par_ok_flag", bus.parity_err, 32'h0);
    pop_once();
`endif

    // Randomized stream, scoreboarded by the monitor
    auto_pop = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 7) != 0);
      send_frame(b, st, ^b);
      idle($urandom_range(4, 30));
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'h0);
    check("rand_ferr", bus.frame_err, {31'h0, any_bad_stop});
    check("rand_ovr", bus.overrun, 32'h0);
    auto_pop = 1'b0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate; CPB = SYS_CLK_FREQ/BAUD_RATE (integer division, CPB >= 4).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  serial line driven by the peer Tx; idle high, 8N1 frame, LSB first.
REQ-006 SHALL have port rd_en  input  1  consumer pop strobe for the held byte.
REQ-007 SHALL have port clear_err  input  1  clears all sticky error flags.
REQ-008 SHALL have port rx_data  output  8  last accepted byte.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unread byte.
REQ-010 SHALL have port overrun  output  1  sticky: a good byte was dropped because rx_valid was held.
REQ-011 SHALL have port frame_err  output  1  sticky: stop bit sampled low.
REQ-012 SHALL have port parity_err  output  1  sticky: parity mismatch (see Configuration).

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK with one bit counter (0..CPB-1) and one bit index (0..7).
REQ-015 IDLE: synchronized rx low -> START, counter cleared.
REQ-016 START: at counter = CPB/2-1 sample; low -> DATA, counter cleared, index 0; high -> IDLE (glitch rejected, no flag).
REQ-017 DATA: sample at each counter = CPB-1, shift into bit [index]; after index 7 -> PARITY if enabled, else STOP.
REQ-018 STOP: sample at counter = CPB-1; high -> frame accepted, IDLE; low -> frame_err set, byte discarded, BREAK.
REQ-019 BREAK: stay until synchronized rx high, then IDLE.
REQ-020 Accepted byte: rx_data and rx_valid update on the cycle after the stop sample.
REQ-021 rx_valid SHALL stay high and rx_data stable until a cycle with rd_en=1 and rx_valid=1, which clears rx_valid next cycle.
REQ-022 rd_en with rx_valid=0 SHALL be ignored.
REQ-023 Byte accepted while rx_valid=1 and rd_en=0: overrun set, new byte dropped, old byte kept.
REQ-024 Byte accepted in the same cycle as a pop: new byte loaded, rx_valid remains 1, no overrun.
REQ-025 clear_err clears overrun, frame_err, parity_err; a set event in the same cycle wins.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, all error flags 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release a fresh start bit is required.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: one even-parity bit follows bit 7, sampled in PARITY at counter = CPB-1; mismatch sets parity_err and discards the byte, stop bit still checked as REQ-018.
REQ-029 Macro undefined: PARITY state absent, frame is 8N1, parity_err tied 0.

Verification (SYS_CLK_FREQ=1000000, BAUD_RATE=100000, CPB=10)
REQ-030 Send 8'hA5 with valid stop -> rx_valid=1, rx_data=8'hA5, all flags 0; rd_en one cycle -> rx_valid=0.
REQ-031 Send 8'h3C, no pop, then 8'h7E -> rx_data stays 8'h3C, overrun=1; clear_err -> overrun=0.
REQ-032 Send 8'h55 with stop bit low, then hold rx low 30 cycles -> frame_err=1, rx_valid=0, no new frame until rx high.
REQ-033 Pulse rx low 3 cycles -> returns to IDLE, rx_valid=0, no flags; following 8'h01 received correctly.
REQ-034 Assert rst_n low mid-byte of 8'hFF -> all outputs reset values; next 8'h12 received as 8'h12.
REQ-035 With UART_RX_PARITY_EN, send 8'h03 with parity bit 1 -> parity_err=1, rx_valid=0; with parity 0 -> rx_data=8'h03.
